// File: rtl/adc_cap_pkg.sv
// Shared types and default constants for the ADC frame-capture block.
package adc_cap_pkg;

    localparam int          FCW_W_DEF    = 32;
    // 5.12 MHz AD0_CLK from the 50 MHz system clock: round(2^32 * 5.12 / 50)
    localparam logic [31:0] FCW_DEF      = 32'd439804651;
    localparam int          DATA_W_DEF   = 8;
    localparam int          DEPTH_DEF    = 1024;
    localparam int          ADDR_W_DEF   = 10;
    localparam logic [7:0]  TRIG_LVL_DEF = 8'd128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;

endpackage

// File: rtl/adc_clk_nco.sv
// Phase-accumulator NCO generating AD0_CLK (registered MSB) and a one-cycle strobe
// that is high in the first cycle AD0_CLK is low after being high.
module adc_clk_nco #(
    parameter int               FCW_W = 32,
    parameter logic [FCW_W-1:0] FCW   = '0
) (
    input  logic clk,
    input  logic reset_n,
    output logic ad0_clk,
    output logic fall_stb
);

    logic [FCW_W-1:0] acc;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc      <= '0;
            ad0_clk  <= 1'b0;
            fall_stb <= 1'b0;
        end else begin
            acc      <= acc + FCW;
            ad0_clk  <= acc[FCW_W-1];
            fall_stb <= ad0_clk & ~acc[FCW_W-1];
        end
    end

endmodule

// File: rtl/adc_frame_capture.sv
// ADC front end: NCO sample clock, AD0 latch on AD0_CLK falling edge, sample stream,
// DEPTH-sample frame RAM. Build option ADC_TRIGGER_EN gates capture on a TRIG_LVL crossing.
module adc_frame_capture
    import adc_cap_pkg::*;
#(
    parameter int               FCW_W  = FCW_W_DEF,
    parameter logic [FCW_W-1:0] FCW    = FCW_W'(FCW_DEF),
    parameter int               DATA_W = DATA_W_DEF,
    parameter int               DEPTH  = DEPTH_DEF,
    parameter int               ADDR_W = ADDR_W_DEF
`ifdef ADC_TRIGGER_EN
    , parameter logic [DATA_W-1:0] TRIG_LVL = DATA_W'(TRIG_LVL_DEF)
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] AD0,
    output logic              AD0_CLK,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_valid,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    cap_state_t        state, state_nxt;
    logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
    logic              fall_stb;
    logic              wr_en;
    logic              arm_go;
    logic [DATA_W-1:0] mem [DEPTH];

    adc_clk_nco #(
        .FCW_W (FCW_W),
        .FCW   (FCW)
    ) u_nco (
        .clk      (clk),
        .reset_n  (reset_n),
        .ad0_clk  (AD0_CLK),
        .fall_stb (fall_stb)
    );

    // AD0 is mid-period stable when AD0_CLK has just fallen.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            smp_data  <= '0;
            smp_valid <= 1'b0;
        end else begin
            smp_valid <= fall_stb;
            if (fall_stb) smp_data <= AD0;
        end
    end

`ifdef ADC_TRIGGER_EN
    logic [DATA_W-1:0] prev_smp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)       prev_smp <= '0;
        else if (smp_valid) prev_smp <= smp_data;
    end

    assign arm_go = smp_valid && (prev_smp < TRIG_LVL) && (smp_data >= TRIG_LVL);
`else
    assign arm_go = 1'b1;
`endif

    assign wr_en = (state == CAPTURE) && smp_valid;

    always_comb begin
        state_nxt   = state;
        wr_addr_nxt = wr_addr;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     if (arm_go) state_nxt = CAPTURE;
            CAPTURE: begin
                if (smp_valid) begin
                    wr_addr_nxt = wr_addr + 1'b1;
                    if (wr_addr == ADDR_W'(DEPTH - 1)) state_nxt = DONE;
                end
            end
            DONE:    if (start) state_nxt = ARM;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            wr_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            wr_addr <= wr_addr_nxt;
            busy    <= (state_nxt == ARM) || (state_nxt == CAPTURE);
            done    <= (state_nxt == DONE);
        end
    end

    // Frame RAM keeps its contents through reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= smp_data;
    end

    // Read-before-write: a same-cycle write to rd_addr returns the old word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_data <= '0;
        else          rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_adc_frame_capture.sv
// Bench for adc_frame_capture: cycle-level reference model compared every clk, random/ramp AD0.
`timescale 1ns/1ps
module tb_adc_frame_capture;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] FCW   = 32'd439804651;
    localparam int          TRIG  = 128;
    localparam int          S_IDLE = 0, S_ARM = 1, S_CAPT = 2, S_DONE = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] AD0 = 8'd0;
    logic       AD0_CLK;
    logic       start = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] smp_data;
    logic       smp_valid;
    logic [9:0] rd_addr = 10'd0;
    logic [7:0] rd_data;

    adc_frame_capture dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .AD0       (AD0),
        .AD0_CLK   (AD0_CLK),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .smp_data  (smp_data),
        .smp_valid (smp_valid),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #10 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int unsigned cyc;
    logic        m_clk1, m_clk2;
    logic        m_valid;
    logic [7:0]  m_data, m_last;
    int          st, wcnt;
    logic [7:0]  m_ram [DEPTH];
    bit          m_known [DEPTH];
    int          ad0_mode;
    logic [7:0]  ramp_v;
    int          ramp_skip;
    logic [7:0]  ramp_last;
    logic        d_prev_clk;
    int          rises, hi_run;
    bit          nco_checked = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 25)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_clk1 = 0; m_clk2 = 0; m_valid = 0; m_data = 0; m_last = 0;
        st = S_IDLE; wcnt = 0; d_prev_clk = 0; rises = 0; hi_run = 0; ramp_skip = 2;
    endtask

    task automatic do_reset();
        #3 reset_n = 1'b0;
        #1;
        chk("rst_ad0_clk", {31'd0, AD0_CLK}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_smp_data", {24'd0, smp_data}, 0);
        chk("rst_smp_valid", {31'd0, smp_valid}, 0);
        chk("rst_rd_data", {24'd0, rd_data}, 0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    // One clock: advance the model across the edge, compare every output, drive AD0.
    task automatic step();
        logic [7:0]  ad0_q, e_data, e_rd;
        logic        start_q, e_clk, e_valid, e_rd_known;
        logic [9:0]  rd_q;
        logic [63:0] ph;
        ad0_q = AD0; start_q = start; rd_q = rd_addr;
        @(posedge clk);
        #1;
        cyc++;
        ph      = 64'(cyc - 1) * 64'(FCW);
        e_clk   = ph[31];
        e_valid = m_clk2 & ~m_clk1;
        e_data  = e_valid ? ad0_q : m_data;
        e_rd_known = m_known[rd_q];
        e_rd       = m_ram[rd_q];
        case (st)
            S_IDLE: if (start_q) st = S_ARM;
            S_ARM: begin
`ifdef ADC_TRIGGER_EN
                if (m_valid && (m_last < TRIG) && (m_data >= TRIG)) st = S_CAPT;
`else
                st = S_CAPT;
`endif
            end
            S_CAPT: if (m_valid) begin
                m_ram[wcnt] = m_data;
                m_known[wcnt] = 1'b1;
                if (wcnt == DEPTH - 1) begin st = S_DONE; wcnt = 0; end
                else wcnt++;
            end
            default: if (start_q) st = S_ARM;
        endcase
        if (m_valid) m_last = m_data;

        chk("ad0_clk", {31'd0, AD0_CLK}, {31'd0, e_clk});
        chk("smp_valid", {31'd0, smp_valid}, {31'd0, e_valid});
        chk("smp_data", {24'd0, smp_data}, {24'd0, e_data});
        chk("busy", {31'd0, busy}, (st == S_ARM || st == S_CAPT) ? 1 : 0);
        chk("done", {31'd0, done}, (st == S_DONE) ? 1 : 0);
        if (e_rd_known) chk("rd_data", {24'd0, rd_data}, {24'd0, e_rd});

        // hand-computed pins: first AD0_CLK rise at cycle 6, 5120+/-1 rises per ms, high 4..6 clk
        if (cyc == 5) chk("nco_first_low", {31'd0, AD0_CLK}, 0);
        if (cyc == 6) chk("nco_first_high", {31'd0, AD0_CLK}, 1);
        if (AD0_CLK && !d_prev_clk) rises++;
        if (AD0_CLK) hi_run++;
        else if (d_prev_clk) begin
            chk("clk_high_width", (hi_run >= 4 && hi_run <= 6) ? 1 : 0, 1);
            hi_run = 0;
        end
        d_prev_clk = AD0_CLK;
        if (cyc == 50000 && !nco_checked) begin
            nco_checked = 1;
            chk("nco_rises_1ms", (rises >= 5119 && rises <= 5121) ? 1 : 0, 1);
        end
        if (ad0_mode == 0 && smp_valid) begin
            if (ramp_skip > 0) ramp_skip--;
            else chk("ramp_step", {24'd0, smp_data}, {24'd0, ramp_last + 8'd1});
            ramp_last = smp_data;
        end

        m_clk2 = m_clk1; m_clk1 = e_clk; m_valid = e_valid; m_data = e_data;
        if (e_clk && !m_clk2) begin
            ramp_v++;
            AD0 = (ad0_mode == 0) ? ramp_v : 8'($urandom_range(0, 255));
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_mode(input int m);
        ad0_mode = m;
        ramp_skip = 2;
    endtask

    task automatic run_until_done(input int budget);
        int k = 0;
        while (!(done === 1'b1) && k < budget) begin
            step();
            k++;
        end
        chk("frame_done_reached", {31'd0, done}, 1);
    endtask

    task automatic readback(input bit ramp_frame);
        logic [7:0] prev = 8'd0;
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 10'(a);
            step();
            if (ramp_frame && a > 0) chk("ram_ramp", {24'd0, rd_data}, {24'd0, prev + 8'd1});
            prev = rd_data;
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        ramp_v = 8'd0; ramp_last = 8'd0; ad0_mode = 0;
        model_reset();
        do_reset();

        // stream: ramp AD0, every code seen exactly once
        set_mode(0);
        run(400);

        // free-run frame with random AD0; extra starts during capture are ignored
        set_mode(1);
        pulse_start();
        run(3000);
        pulse_start();
        run(3000);
        pulse_start();
        run_until_done(15000);
        run(20);
        readback(0);

        // start in DONE re-arms; ramp frame overwrites the RAM
        set_mode(0);
        pulse_start();
        run_until_done(15000);
        readback(1);

        // idle with random reads until the 1 ms NCO window closes
        while (cyc < 50010) begin
            rd_addr = 10'($urandom_range(0, DEPTH - 1));
            step();
        end

        // reset in the middle of a capture, then a full new frame
        set_mode(1);
        pulse_start();
        for (int k = 0; k < 8000 && wcnt < 500; k++) step();
        chk("mid_capture_reached", (wcnt >= 500) ? 1 : 0, 1);
        do_reset();
        run(10);
        pulse_start();
        run_until_done(15000);
        readback(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
